// File: rtl/interpretar_botao_pkg.sv
// Shared definitions for the button-handling chain (debouncer, interpreter, control FSM).
// Holds the interpreter state encoding, the default timing thresholds and a small helper
// that turns a period in samples into the terminal value of a counter that starts at 0.
package interpretar_botao_pkg;

  // Encodings are fixed so other blocks can decode the state directly.
  typedef enum logic [1:0] {
    Ocioso    = 2'd0,
    Contando  = 2'd1,
    Repetindo = 2'd2,
    Bloqueado = 2'd3
  } estado_e;

  // Defaults for a 50 MHz clock: 0.5 s long press, 0.1 s repeat period.
  localparam int unsigned LongoPadrao   = 25_000_000;
  localparam int unsigned RepetePadrao  = 5_000_000;
  localparam int unsigned LarguraPadrao = 26;

  // Last count value of a period of 'ciclos' samples; a zero period maps to 0 so the
  // constant stays in range even when the feature it times is switched off.
  function automatic int unsigned fim_contagem(input int unsigned ciclos);
    return (ciclos == 0) ? 0 : ciclos - 1;
  endfunction

endpackage

// File: rtl/interpretar_botao.sv
// interpretar_botao: turns the debounced button level into discrete events.
//   - pulso_curto : 1-cycle strobe when a press is released before the long threshold
//   - pulso_longo : 1-cycle strobe when the press reaches LONGO_CICLOS high samples
//   - pulso_repete: 1-cycle strobe every REPETE_CICLOS samples after the long strobe
//   - pressionado : level, high while a press is being counted or repeating
// Ports:
//   clock        in  system clock, all logic on posedge
//   reset_n      in  asynchronous reset, active-low
//   botao_limpo  in  debounced button level, active-high, synchronous to clock
//   habilita     in  1 = events allowed; 0 = suppress and lock out the current press
//   pulso_curto, pulso_longo, pulso_repete, pressionado  out  registered
// After reset the block sits in Bloqueado so a button held through reset never produces
// events; a release is always required before a new press is recognised.
module interpretar_botao
  import interpretar_botao_pkg::*;
#(
  parameter int unsigned LONGO_CICLOS  = LongoPadrao,
  parameter int unsigned REPETE_CICLOS = RepetePadrao,
  parameter int unsigned LARGURA_CONT  = LarguraPadrao
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao_limpo,
  input  logic habilita,
  output logic pulso_curto,
  output logic pulso_longo,
  output logic pulso_repete,
  output logic pressionado
);

  localparam logic [LARGURA_CONT-1:0] LongoFim  = LARGURA_CONT'(fim_contagem(LONGO_CICLOS));
  localparam logic [LARGURA_CONT-1:0] RepeteFim = LARGURA_CONT'(fim_contagem(REPETE_CICLOS));
  localparam logic [LARGURA_CONT-1:0] ContUm    = LARGURA_CONT'(1);
  localparam bit                      RepeteDesligado = (REPETE_CICLOS == 0);

  estado_e                 estado_q, estado_d;
  logic [LARGURA_CONT-1:0] contador_q, contador_d;
  logic                    curto_q, curto_d;
  logic                    longo_q, longo_d;
  logic                    repete_q, repete_d;
  logic                    pressionado_q, pressionado_d;

  // Next-state logic. Priority inside every active state: habilita low, then release,
  // then terminal count. Any state change clears the counter so it can never wrap.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    curto_d    = 1'b0;
    longo_d    = 1'b0;
    repete_d   = 1'b0;

    unique case (estado_q)
      Ocioso: begin
        if (habilita && botao_limpo) begin
          estado_d   = Contando;
          contador_d = ContUm;  // the edge that starts the press is the first sample
        end
      end

      Contando: begin
        if (!habilita) begin
          // A press still held must be released before it can count again.
          estado_d   = botao_limpo ? Bloqueado : Ocioso;
          contador_d = '0;
        end else if (!botao_limpo) begin
          estado_d   = Ocioso;
          contador_d = '0;
          curto_d    = 1'b1;
        end else if (contador_q == LongoFim) begin
          estado_d   = Repetindo;
          contador_d = '0;
          longo_d    = 1'b1;
        end else begin
          contador_d = contador_q + ContUm;
        end
      end

      Repetindo: begin
        if (!habilita) begin
          estado_d   = botao_limpo ? Bloqueado : Ocioso;
          contador_d = '0;
        end else if (!botao_limpo) begin
          // Release after a long press is silent: the long strobe already reported it.
          estado_d   = Ocioso;
          contador_d = '0;
        end else if (RepeteDesligado) begin
          contador_d = contador_q;
        end else if (contador_q == RepeteFim) begin
          contador_d = '0;
          repete_d   = 1'b1;
        end else begin
          contador_d = contador_q + ContUm;
        end
      end

      Bloqueado: begin
        if (!botao_limpo) begin
          estado_d   = Ocioso;
          contador_d = '0;
        end
      end

      default: begin
        estado_d   = Bloqueado;
        contador_d = '0;
      end
    endcase

    pressionado_d = (estado_d == Contando) || (estado_d == Repetindo);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= Bloqueado;
      contador_q    <= '0;
      curto_q       <= 1'b0;
      longo_q       <= 1'b0;
      repete_q      <= 1'b0;
      pressionado_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      contador_q    <= contador_d;
      curto_q       <= curto_d;
      longo_q       <= longo_d;
      repete_q      <= repete_d;
      pressionado_q <= pressionado_d;
    end
  end

  assign pulso_curto  = curto_q;
  assign pulso_longo  = longo_q;
  assign pulso_repete = repete_q;
  assign pressionado  = pressionado_q;

endmodule

// File: tb/tb_interpretar_botao.sv
module tb_interpretar_botao;

  localparam int L = 8;
  localparam int R = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic botao_limpo = 1'b0;
  logic habilita = 1'b1;
  logic pulso_curto, pulso_longo, pulso_repete, pressionado;

  int total = 0;
  int bad = 0;

  int n_curto = 0;
  int n_longo = 0;
  int n_repete = 0;

  interpretar_botao #(
    .LONGO_CICLOS (L),
    .REPETE_CICLOS(R),
    .LARGURA_CONT (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .botao_limpo (botao_limpo),
    .habilita    (habilita),
    .pulso_curto (pulso_curto),
    .pulso_longo (pulso_longo),
    .pulso_repete(pulso_repete),
    .pressionado (pressionado)
  );

  always #5 clock = ~clock;

  // Model: n = number of enabled high samples in the current press (0 = no press),
  // trava = a release must be seen before a new press counts.
  typedef struct packed {
    int n;
    bit trava;
    bit c;
    bit lg;
    bit rp;
    bit p;
  } modelo_t;

  localparam modelo_t ModeloReset = '{n: 0, trava: 1'b1, c: 1'b0, lg: 1'b0, rp: 1'b0, p: 1'b0};

  modelo_t m = ModeloReset;

  function automatic modelo_t prox(input modelo_t s, input logic b, input logic h);
    modelo_t r;
    r = s;
    r.c = 1'b0;
    r.lg = 1'b0;
    r.rp = 1'b0;
    if (s.trava) begin
      if (!b) r.trava = 1'b0;
    end else if (s.n == 0) begin
      if (b && h) r.n = 1;
    end else if (!h) begin
      r.trava = b;
      r.n = 0;
    end else if (!b) begin
      r.c = (s.n < L);
      r.n = 0;
    end else begin
      r.n = s.n + 1;
      r.lg = (r.n == L);
      r.rp = (R != 0) && (r.n > L) && (((r.n - L) % R) == 0);
    end
    r.p = (r.n > 0);
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= ModeloReset;
    else          m <= prox(m, botao_limpo, habilita);
  end

  task automatic verifica(input string nome, input int atual, input int esperado);
    total++;
    if (atual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clock) begin
    verifica("curto", int'(pulso_curto), int'(m.c));
    verifica("longo", int'(pulso_longo), int'(m.lg));
    verifica("repete", int'(pulso_repete), int'(m.rp));
    verifica("pressionado", int'(pressionado), int'(m.p));
    verifica("one_hot", int'(pulso_curto) + int'(pulso_longo) + int'(pulso_repete) <= 1, 1);
    if (pulso_curto)  n_curto++;
    if (pulso_longo)  n_longo++;
    if (pulso_repete) n_repete++;
  end

  task automatic amostra(input logic b, input logic h);
    @(negedge clock);
    botao_limpo = b;
    habilita = h;
    @(posedge clock);
    #1;
  endtask

  task automatic repete_amostra(input logic b, input int k);
    for (int i = 0; i < k; i++) amostra(b, 1'b1);
  endtask

  task automatic confere_contagem(input string nome, input int bc, input int bl, input int br,
                                  input int ec, input int el, input int er);
    verifica({nome, "_n_curto"}, n_curto - bc, ec);
    verifica({nome, "_n_longo"}, n_longo - bl, el);
    verifica({nome, "_n_repete"}, n_repete - br, er);
  endtask

  initial begin
    int bc, bl, br;

    // 1: reset with button low, then idle
    #3 reset_n = 1'b0;
    #1;
    verifica("reset_curto", int'(pulso_curto), 0);
    verifica("reset_longo", int'(pulso_longo), 0);
    verifica("reset_repete", int'(pulso_repete), 0);
    verifica("reset_pressionado", int'(pressionado), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b0, 20);
    confere_contagem("t1", bc, bl, br, 0, 0, 0);

    // 2: three high samples -> short press on release
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 3);
    amostra(1'b0, 1'b1);
    verifica("t2_curto_after_release", int'(pulso_curto), 1);
    repete_amostra(1'b0, 4);
    confere_contagem("t2", bc, bl, br, 1, 0, 0);

    // 3a: seven high samples -> still short (release wins at terminal count)
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 7);
    verifica("t3a_no_longo_at_7", int'(pulso_longo), 0);
    repete_amostra(1'b0, 5);
    confere_contagem("t3a", bc, bl, br, 1, 0, 0);

    // 3b: eight high samples -> long, no short on release
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 8);
    verifica("t3b_longo_at_8", int'(pulso_longo), 1);
    repete_amostra(1'b0, 5);
    confere_contagem("t3b", bc, bl, br, 0, 1, 0);

    // 4: twenty high samples -> long at 8, repeats at 11,14,17,20
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 11);
    verifica("t4_repete_at_11", int'(pulso_repete), 1);
    repete_amostra(1'b1, 9);
    verifica("t4_repete_at_20", int'(pulso_repete), 1);
    verifica("t4_pressionado_held", int'(pressionado), 1);
    amostra(1'b0, 1'b1);
    verifica("t4_pressionado_release", int'(pressionado), 0);
    repete_amostra(1'b0, 9);
    confere_contagem("t4", bc, bl, br, 0, 1, 4);

    // 5: habilita drops mid-press, returns while held -> silent until release
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 4);
    amostra(1'b1, 1'b0);
    verifica("t5_pressionado_locked", int'(pressionado), 0);
    repete_amostra(1'b1, 10);
    repete_amostra(1'b0, 3);
    confere_contagem("t5_locked", bc, bl, br, 0, 0, 0);
    bc = n_curto; bl = n_longo; br = n_repete;
    repete_amostra(1'b1, 3);
    repete_amostra(1'b0, 3);
    confere_contagem("t5_fresh", bc, bl, br, 1, 0, 0);

    // 6a: button held across reset release
    bc = n_curto; bl = n_longo; br = n_repete;
    amostra(1'b1, 1'b1);
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repete_amostra(1'b1, 15);
    repete_amostra(1'b0, 3);
    confere_contagem("t6a", bc, bl, br, 0, 0, 0);

    // 6b: reset mid-repeat clears outputs at once
    repete_amostra(1'b1, 12);
    verifica("t6b_pressionado_before", int'(pressionado), 1);
    #2 reset_n = 1'b0;
    #1;
    verifica("t6b_async_pressionado", int'(pressionado), 0);
    verifica("t6b_async_curto", int'(pulso_curto), 0);
    verifica("t6b_async_longo", int'(pulso_longo), 0);
    verifica("t6b_async_repete", int'(pulso_repete), 0);
    bc = n_curto; bl = n_longo; br = n_repete;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repete_amostra(1'b1, 10);
    repete_amostra(1'b0, 4);
    confere_contagem("t6b", bc, bl, br, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
